// File: rtl/sta_tile_scheduler_pkg.sv
// Shared types for the systolic tensor array tile scheduler.
// SA_N must match the array dimension used by the STA datapath.
package sta_tile_scheduler_pkg;

  localparam int SA_N = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    BIAS,
    FEED,
    DRAIN,
    DONE,
    RETIRE,
    LAST
  } sched_state_e;

endpackage

// File: rtl/sta_tile_scheduler_if.sv
// Control/status bundle between the tile scheduler (master) and the STA datapath wrapper (slave).
interface sta_tile_scheduler_if #(
  parameter int N_BITS = 6
);
  logic              stall;
  logic              sta_idle;
  logic              chain_idle;
  logic              reset_sta;
  logic              load_bias;
  logic              feed_en;
  logic              feed_last;
  logic              done;
  logic [N_BITS-1:0] pos_row;
  logic [N_BITS-1:0] pos_col;
  logic [2:0]        layer_idx;

  modport master (
    input  stall, sta_idle, chain_idle,
    output reset_sta, load_bias, feed_en, feed_last, done, pos_row, pos_col, layer_idx
  );

  modport slave (
    output stall, sta_idle, chain_idle,
    input  reset_sta, load_bias, feed_en, feed_last, done, pos_row, pos_col, layer_idx
  );
endinterface

// File: rtl/sta_tile_scheduler_tile_walker.sv
// Row-major tile coordinate stepper; coordinates are kept one bit wider than the
// output so base+SA_N never wraps before being compared against the layer size.
module tile_walker
  import sta_tile_scheduler_pkg::*;
#(
  parameter int N_BITS = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              advance,
  input  logic [N_BITS:0]   rows,
  input  logic [N_BITS:0]   cols,
  output logic [N_BITS-1:0] pos_row,
  output logic [N_BITS-1:0] pos_col,
  output logic              last
);

  localparam logic [N_BITS:0] STEP = (N_BITS+1)'(SA_N);

  logic [N_BITS:0] row;
  logic [N_BITS:0] col;
  logic [N_BITS:0] row_inc;
  logic [N_BITS:0] col_inc;

  assign row_inc = row + STEP;
  assign col_inc = col + STEP;
  assign last    = (col_inc >= cols) && (row_inc >= rows);
  assign pos_row = row[N_BITS-1:0];
  assign pos_col = col[N_BITS-1:0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      row <= '0;
      col <= '0;
    end else if (clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_inc >= cols) begin
        col <= '0;
        row <= row_inc;
      end else begin
        col <= col_inc;
      end
    end
  end

endmodule

// File: rtl/sta_tile_scheduler.sv
// Tile scheduler for the 4x4 systolic tensor array: walks one layer tile by tile
// and sequences bias load, operand feed, drain, done and post-processing retire.
//
// state  | meaning
// IDLE   | waiting for start
// CLR    | reset_sta pulse, tile coordinates at 0,0
// BIAS   | load_bias pulse for the current tile
// FEED   | k_len operand vectors presented
// DRAIN  | waiting for the STA to report idle
// DONE   | done pulse to the output coordinator
// RETIRE | waiting for chain_idle on two consecutive cycles
// LAST   | layer_done pulse
module sta_tile_scheduler
  import sta_tile_scheduler_pkg::*;
#(
  parameter int MAX_N  = 64,
  parameter int N_BITS = $clog2(MAX_N),
  parameter int MAX_K  = 1024,
  parameter int K_BITS = $clog2(MAX_K + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N_BITS:0]   cfg_rows,
  input  logic [N_BITS:0]   cfg_cols,
  input  logic [K_BITS-1:0] cfg_k_len,
  input  logic [2:0]        cfg_layer_idx,
  output logic              busy,
  output logic              cfg_err,
  output logic              layer_done,
  sta_tile_scheduler_if.master dp
);

  localparam logic [N_BITS:0]   N_LIM = (N_BITS+1)'(MAX_N);
  localparam logic [K_BITS-1:0] K_LIM = K_BITS'(MAX_K);

  sched_state_e      state;
  sched_state_e      state_nxt;
  logic [N_BITS:0]   rows_q;
  logic [N_BITS:0]   cols_q;
  logic [K_BITS-1:0] k_len_q;
  logic [K_BITS-1:0] k_cnt;
  logic [2:0]        layer_idx_q;
  logic              idle_seen;
  logic              cfg_ok;
  logic              accept;
  logic              k_final;
  logic              retire_go;
  logic              walk_step;
  logic              last_tile;
  logic              reset_sta_c;
  logic              load_bias_c;
  logic              feed_en_c;
  logic              feed_last_c;
  logic              done_c;

  assign cfg_ok = (cfg_rows != '0) && (cfg_rows <= N_LIM) &&
                  (cfg_cols != '0) && (cfg_cols <= N_LIM) &&
                  (cfg_k_len != '0) && (cfg_k_len <= K_LIM);
  assign accept    = (state == IDLE) && start && cfg_ok;
  assign k_final   = (k_cnt == k_len_q - K_BITS'(1));
  assign retire_go = (state == RETIRE) && !dp.stall && dp.chain_idle && idle_seen;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    busy        = 1'b1;
    layer_done  = 1'b0;
    reset_sta_c = 1'b0;
    load_bias_c = 1'b0;
    feed_en_c   = 1'b0;
    feed_last_c = 1'b0;
    done_c      = 1'b0;
    walk_step   = 1'b0;
    unique case (state)
      IDLE: begin
        busy = 1'b0;
        if (accept) state_nxt = CLR;
      end
      CLR: if (!dp.stall) begin
        reset_sta_c = 1'b1;
        state_nxt   = BIAS;
      end
      BIAS: if (!dp.stall) begin
        load_bias_c = 1'b1;
        state_nxt   = FEED;
      end
      FEED: if (!dp.stall) begin
        feed_en_c   = 1'b1;
        feed_last_c = k_final;
        if (k_final) state_nxt = DRAIN;
      end
      DRAIN: if (!dp.stall && dp.sta_idle) state_nxt = DONE;
      DONE: if (!dp.stall) begin
        done_c    = 1'b1;
        state_nxt = RETIRE;
      end
      RETIRE: if (retire_go) begin
        if (last_tile) begin
          state_nxt = LAST;
        end else begin
          walk_step = 1'b1;
          state_nxt = BIAS;
        end
      end
      LAST: begin
        busy       = 1'b0;
        layer_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rows_q      <= '0;
      cols_q      <= '0;
      k_len_q     <= '0;
      layer_idx_q <= '0;
      k_cnt       <= '0;
      idle_seen   <= 1'b0;
      cfg_err     <= 1'b0;
    end else begin
      cfg_err <= (state == IDLE) && start && !cfg_ok;
      if (accept) begin
        rows_q      <= cfg_rows;
        cols_q      <= cfg_cols;
        k_len_q     <= cfg_k_len;
        layer_idx_q <= cfg_layer_idx;
      end
      if (feed_en_c) k_cnt <= k_final ? '0 : k_cnt + K_BITS'(1);
      // two consecutive idle samples bridge the oc->requant hand-off gap
      if (state != RETIRE)  idle_seen <= 1'b0;
      else if (!dp.stall)   idle_seen <= dp.chain_idle && !retire_go;
    end
  end

  tile_walker #(.N_BITS(N_BITS)) u_walker (
    .clk     (clk),
    .reset   (reset),
    .clear   (accept),
    .advance (walk_step),
    .rows    (rows_q),
    .cols    (cols_q),
    .pos_row (dp.pos_row),
    .pos_col (dp.pos_col),
    .last    (last_tile)
  );

  assign dp.reset_sta = reset_sta_c;
  assign dp.load_bias = load_bias_c;
  assign dp.feed_en   = feed_en_c;
  assign dp.feed_last = feed_last_c;
  assign dp.done      = done_c;
  assign dp.layer_idx = layer_idx_q;

endmodule
